// File: rtl/nvme_pcie_cmd_arbiter.sv
// Round-robin arbiter sharing one NVMe PCIe register-access master between NUM_REQ requesters.
// One access is outstanding at a time, bounded by a timeout; a timed-out access is drained before reuse.
module nvme_pcie_cmd_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_BITS       = 16
) (
   input  logic                    axi_aclk,
   input  logic                    axi_aresetn,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_write,
   input  logic [NUM_REQ*32-1:0]   req_addr,
   input  logic [NUM_REQ*32-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [31:0]             resp_rdata,
   output logic                    resp_error,
   output logic                    pcie_write,
   output logic [31:0]             pcie_waddr,
   output logic [31:0]             pcie_wdata,
   input  logic                    pcie_wdone,
   input  logic                    pcie_werror,
   output logic                    pcie_read,
   output logic [31:0]             pcie_raddr,
   input  logic [31:0]             pcie_rdata,
   input  logic                    pcie_rdone,
   input  logic                    pcie_rerror,
   output logic                    busy,
   output logic [CNT_BITS-1:0]     err_count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_BITS-1:0] TO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 wr_q, wr_d;
   logic [CNT_BITS-1:0]  cnt_q, cnt_d;
   logic [CNT_BITS-1:0]  err_count_q, err_count_d;
   logic                 pcie_write_q, pcie_write_d;
   logic                 pcie_read_q, pcie_read_d;
   logic [31:0]          pcie_waddr_q, pcie_waddr_d;
   logic [31:0]          pcie_wdata_q, pcie_wdata_d;
   logic [31:0]          pcie_raddr_q, pcie_raddr_d;
   logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
   logic [31:0]          resp_rdata_q, resp_rdata_d;
   logic                 resp_error_q, resp_error_d;
   logic                 busy_q, busy_d;

   logic [31:0]          addr_arr  [NUM_REQ];
   logic [31:0]          wdata_arr [NUM_REQ];
   logic [IDX_W-1:0]     gnt_idx;
   logic                 gnt_any;
   logic                 idle;
   logic                 done_match;
   logic                 err_match;
   logic                 err_inc;

   assign idle = (state_q == ST_IDLE);

   // Only the completion for the latched direction counts; the other strobe is ignored.
   assign done_match = wr_q ? pcie_wdone  : pcie_rdone;
   assign err_match  = wr_q ? pcie_werror : pcie_rerror;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign addr_arr[gi]  = req_addr[gi*32 +: 32];
         assign wdata_arr[gi] = req_wdata[gi*32 +: 32];
         assign req_ready[gi] = idle && gnt_any && (gnt_idx == IDX_W'(gi));
      end
   endgenerate

   // Scan from the farthest offset back to the nearest so the first valid after rr_ptr wins.
   always_comb begin : grant_scan
      logic [IDX_W-1:0] cand_idx;
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      cand_idx = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand_idx = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
         if (req_valid[cand_idx]) begin
            gnt_idx = cand_idx;
            gnt_any = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      idx_d        = idx_q;
      wr_d         = wr_q;
      cnt_d        = cnt_q;
      err_count_d  = err_count_q;
      pcie_write_d = 1'b0;
      pcie_read_d  = 1'b0;
      pcie_waddr_d = pcie_waddr_q;
      pcie_wdata_d = pcie_wdata_q;
      pcie_raddr_d = pcie_raddr_q;
      resp_valid_d = '0;
      resp_rdata_d = resp_rdata_q;
      resp_error_d = resp_error_q;
      err_inc      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               idx_d    = gnt_idx;
               rr_ptr_d = gnt_idx;
               wr_d     = req_write[gnt_idx];
               if (req_write[gnt_idx]) begin
                  pcie_write_d = 1'b1;
                  pcie_waddr_d = addr_arr[gnt_idx];
                  pcie_wdata_d = wdata_arr[gnt_idx];
               end else begin
                  pcie_read_d  = 1'b1;
                  pcie_raddr_d = addr_arr[gnt_idx];
               end
               state_d = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (done_match) begin
               resp_valid_d[idx_q] = 1'b1;
               resp_rdata_d        = wr_q ? 32'h0 : pcie_rdata;
               resp_error_d        = err_match;
               err_inc             = err_match;
               pcie_waddr_d        = '0;
               pcie_wdata_d        = '0;
               pcie_raddr_d        = '0;
               state_d             = ST_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
               // Address/data stay driven while the late completion is drained.
               resp_valid_d[idx_q] = 1'b1;
               resp_rdata_d        = 32'hFFFF_FFFF;
               resp_error_d        = 1'b1;
               err_inc             = 1'b1;
               state_d             = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         ST_DRAIN: begin
            if (done_match) begin
               pcie_waddr_d = '0;
               pcie_wdata_d = '0;
               pcie_raddr_d = '0;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (err_inc && (err_count_q != '1)) begin
         err_count_d = err_count_q + 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
         idx_q        <= '0;
         wr_q         <= 1'b0;
         cnt_q        <= '0;
         err_count_q  <= '0;
         pcie_write_q <= 1'b0;
         pcie_read_q  <= 1'b0;
         pcie_waddr_q <= '0;
         pcie_wdata_q <= '0;
         pcie_raddr_q <= '0;
         resp_valid_q <= '0;
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         idx_q        <= idx_d;
         wr_q         <= wr_d;
         cnt_q        <= cnt_d;
         err_count_q  <= err_count_d;
         pcie_write_q <= pcie_write_d;
         pcie_read_q  <= pcie_read_d;
         pcie_waddr_q <= pcie_waddr_d;
         pcie_wdata_q <= pcie_wdata_d;
         pcie_raddr_q <= pcie_raddr_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_error_q <= resp_error_d;
         busy_q       <= busy_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_error = resp_error_q;
   assign pcie_write = pcie_write_q;
   assign pcie_waddr = pcie_waddr_q;
   assign pcie_wdata = pcie_wdata_q;
   assign pcie_read  = pcie_read_q;
   assign pcie_raddr = pcie_raddr_q;
   assign busy       = busy_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_nvme_pcie_cmd_arbiter.sv
// Directed bench for nvme_pcie_cmd_arbiter: table of transactions with hand-computed responses,
// plus hand-written round-robin, timeout/drain and mid-access reset sequences.
module tb_nvme_pcie_cmd_arbiter;

   logic        axi_aclk;
   logic        axi_aresetn;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        pcie_write;
   logic [31:0] pcie_waddr;
   logic [31:0] pcie_wdata;
   logic        pcie_wdone;
   logic        pcie_werror;
   logic        pcie_read;
   logic [31:0] pcie_raddr;
   logic [31:0] pcie_rdata;
   logic        pcie_rdone;
   logic        pcie_rerror;
   logic        busy;
   logic [15:0] err_count;

   int checks   = 0;
   int failures = 0;

   nvme_pcie_cmd_arbiter #(
      .NUM_REQ        (2),
      .TIMEOUT_CYCLES (8),
      .CNT_BITS       (16)
   ) dut (
      .axi_aclk    (axi_aclk),
      .axi_aresetn (axi_aresetn),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_error  (resp_error),
      .pcie_write  (pcie_write),
      .pcie_waddr  (pcie_waddr),
      .pcie_wdata  (pcie_wdata),
      .pcie_wdone  (pcie_wdone),
      .pcie_werror (pcie_werror),
      .pcie_read   (pcie_read),
      .pcie_raddr  (pcie_raddr),
      .pcie_rdata  (pcie_rdata),
      .pcie_rdone  (pcie_rdone),
      .pcie_rerror (pcie_rerror),
      .busy        (busy),
      .err_count   (err_count)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      int          id;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;        // cycles after the strobe at which the matching done arrives
      bit          derr;
      logic [31:0] drdata;     // data the master presents with done
      int          mis_lat;    // cycle of a wrong-direction done pulse (0 = none)
      logic [31:0] exp_rdata;
      bit          exp_err;
      logic [15:0] exp_errcnt;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge axi_aclk);
      #2;
   endtask

   task automatic clear_done;
      pcie_wdone  = 1'b0;
      pcie_werror = 1'b0;
      pcie_rdone  = 1'b0;
      pcie_rerror = 1'b0;
      pcie_rdata  = 32'h0;
   endtask

   task automatic drive_done(input bit wr, input bit err, input logic [31:0] data);
      if (wr) begin
         pcie_wdone  = 1'b1;
         pcie_werror = err;
      end else begin
         pcie_rdone  = 1'b1;
         pcie_rerror = err;
      end
      pcie_rdata = data;
   endtask

   // Present a request on slot id, wait for its grant, play the PCIe master and check the response.
   task automatic serve(input int id, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input bit derr, input logic [31:0] drdata, input int mis_lat,
                        input logic [31:0] exp_rdata, input bit exp_err, input logic [15:0] exp_errcnt,
                        input bit drop);
      logic [1:0] oh;
      int n;
      int extra_strobe;
      int early;
      oh = 2'b01 << id;
      req_valid[id]            = 1'b1;
      req_write[id]            = wr;
      req_addr[id*32 +: 32]    = addr;
      req_wdata[id*32 +: 32]   = wdata;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         tick;
         n++;
      end
      chk("grant", {62'b0, req_ready}, {62'b0, oh});
      tick;
      if (drop) req_valid[id] = 1'b0;
      chk("strobe_wr", {63'b0, pcie_write}, {63'b0, wr});
      chk("strobe_rd", {63'b0, pcie_read}, {63'b0, !wr});
      if (wr) begin
         chk("waddr", {32'b0, pcie_waddr}, {32'b0, addr});
         chk("wdata", {32'b0, pcie_wdata}, {32'b0, wdata});
      end else begin
         chk("raddr", {32'b0, pcie_raddr}, {32'b0, addr});
      end
      chk("busy_issue", {63'b0, busy}, 64'd1);
      extra_strobe = 0;
      early = 0;
      for (int c = 1; c <= lat; c++) begin
         tick;
         clear_done;
         if (pcie_write || pcie_read) extra_strobe++;
         if (resp_valid != 2'b00) early++;
         if (c == mis_lat) drive_done(!wr, 1'b1, 32'hEEEE_EEEE);
         if (c == lat) drive_done(wr, derr, drdata);
      end
      tick;
      clear_done;
      chk("extra_strobe", extra_strobe, 0);
      chk("early_resp", early, 0);
      chk("resp_valid", {62'b0, resp_valid}, {62'b0, oh});
      chk("resp_rdata", {32'b0, resp_rdata}, {32'b0, exp_rdata});
      chk("resp_error", {63'b0, resp_error}, {63'b0, exp_err});
      chk("err_count", {48'b0, err_count}, {48'b0, exp_errcnt});
      tick;
      chk("resp_pulse_end", {62'b0, resp_valid}, 64'd0);
      chk("busy_idle", {63'b0, busy}, 64'd0);
   endtask

   initial begin
      int early;
      int blocked;
      int not_busy;
      logic [31:0] rr_addr  [2];
      logic [31:0] rr_wdata [2];

      vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'h0,          3, 1'b0, 32'hCAFE_0001, 0, 32'hCAFE_0001, 1'b0, 16'd0};
      vecs[1] = '{1, 1'b1, 32'h0000_1004, 32'h1111_2222,  1, 1'b0, 32'hA5A5_A5A5, 0, 32'h0,         1'b0, 16'd0};
      vecs[2] = '{0, 1'b1, 32'h0000_1008, 32'hDEAD_BEEF,  2, 1'b1, 32'hA5A5_A5A5, 0, 32'h0,         1'b1, 16'd1};
      vecs[3] = '{1, 1'b0, 32'h0000_2000, 32'h0,          5, 1'b1, 32'h1234_5678, 2, 32'h1234_5678, 1'b1, 16'd2};
      vecs[4] = '{0, 1'b0, 32'h0000_3000, 32'h0,          1, 1'b0, 32'h8000_0001, 0, 32'h8000_0001, 1'b0, 16'd2};
      vecs[5] = '{1, 1'b1, 32'h0000_3004, 32'h5555_AAAA,  7, 1'b0, 32'hA5A5_A5A5, 3, 32'h0,         1'b0, 16'd2};
      vecs[6] = '{0, 1'b0, 32'h0000_3008, 32'h0,          8, 1'b0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 16'd2};

      axi_aresetn = 1'b0;
      req_valid   = 2'b00;
      req_write   = 2'b00;
      req_addr    = '0;
      req_wdata   = '0;
      clear_done;

      // Reset state
      tick;
      tick;
      chk("rst_req_ready", {62'b0, req_ready}, 64'd0);
      chk("rst_resp_valid", {62'b0, resp_valid}, 64'd0);
      chk("rst_strobes", {62'b0, pcie_write, pcie_read}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_err_count", {48'b0, err_count}, 64'd0);
      chk("rst_addr", {pcie_waddr, pcie_raddr}, 64'd0);
      axi_aresetn = 1'b1;
      tick;

      // Round-robin: both requesters hold writes; grants must alternate 0,1,0,1
      rr_addr[0]  = 32'h0000_0100;  rr_wdata[0] = 32'hA0A0_0000;
      rr_addr[1]  = 32'h0000_0200;  rr_wdata[1] = 32'hB1B1_1111;
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr  = {rr_addr[1], rr_addr[0]};
      req_wdata = {rr_wdata[1], rr_wdata[0]};
      for (int k = 0; k < 4; k++) begin
         serve(k % 2, 1'b1, rr_addr[k % 2], rr_wdata[k % 2], 1, 1'b0, 32'hA5A5_A5A5, 0,
               32'h0, 1'b0, 16'd0, 1'b0);
      end
      req_valid = 2'b00;
      tick;

      // Table-driven transactions
      for (int i = 0; i < 7; i++) begin
         serve(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].derr,
               vecs[i].drdata, vecs[i].mis_lat, vecs[i].exp_rdata, vecs[i].exp_err,
               vecs[i].exp_errcnt, 1'b1);
         $display("txn %0d id=%0d wr=%0d addr=%h lat=%0d -> rdata=%h err=%0d", i, vecs[i].id,
                  vecs[i].wr, vecs[i].addr, vecs[i].lat, resp_rdata, resp_error);
      end

      // Timeout: read with no rdone, requester 1 waiting behind it
      req_valid[0]      = 1'b1;
      req_write[0]      = 1'b0;
      req_addr[31:0]    = 32'h0000_4000;
      #1;
      chk("to_grant", {62'b0, req_ready}, 64'd1);
      tick;
      chk("to_strobe", {63'b0, pcie_read}, 64'd1);
      chk("to_raddr", {32'b0, pcie_raddr}, 64'h4000);
      req_valid[0]       = 1'b0;
      req_valid[1]       = 1'b1;
      req_write[1]       = 1'b1;
      req_addr[63:32]    = 32'h0000_4004;
      req_wdata[63:32]   = 32'h7777_0000;
      early = 0;
      blocked = 0;
      for (int c = 1; c <= 8; c++) begin
         tick;
         if (resp_valid != 2'b00) early++;
         if (req_ready != 2'b00) blocked++;
      end
      chk("to_early", early, 0);
      tick;
      chk("to_resp_valid", {62'b0, resp_valid}, 64'd1);
      chk("to_rdata", {32'b0, resp_rdata}, 64'hFFFF_FFFF);
      chk("to_error", {63'b0, resp_error}, 64'd1);
      chk("to_err_count", {48'b0, err_count}, 64'd3);
      chk("to_busy", {63'b0, busy}, 64'd1);
      early = 0;
      not_busy = 0;
      for (int c = 10; c <= 20; c++) begin
         tick;
         clear_done;
         if (resp_valid != 2'b00) early++;
         if (req_ready != 2'b00) blocked++;
         if (!busy) not_busy++;
         if (c == 14) drive_done(1'b1, 1'b0, 32'h0);
         if (c == 20) drive_done(1'b0, 1'b0, 32'h1357_9BDF);
      end
      tick;
      clear_done;
      chk("drain_no_resp", early, 0);
      chk("drain_blocked", blocked, 0);
      chk("drain_busy", not_busy, 0);
      chk("drain_exit_busy", {63'b0, busy}, 64'd0);
      chk("drain_exit_resp", {62'b0, resp_valid}, 64'd0);
      chk("drain_exit_ready", {62'b0, req_ready}, 64'd2);
      chk("drain_err_count", {48'b0, err_count}, 64'd3);
      serve(1, 1'b1, 32'h0000_4004, 32'h7777_0000, 2, 1'b0, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 16'd3, 1'b1);

      // Asynchronous reset while an access is in WAIT
      req_valid[0]   = 1'b1;
      req_write[0]   = 1'b0;
      req_addr[31:0] = 32'h0000_5000;
      #1;
      chk("rw_grant", {62'b0, req_ready}, 64'd1);
      tick;
      req_valid[0] = 1'b0;
      tick;
      tick;
      chk("rw_in_wait", {63'b0, busy}, 64'd1);
      #3;
      axi_aresetn = 1'b0;
      #1;
      chk("rw_busy", {63'b0, busy}, 64'd0);
      chk("rw_raddr", {32'b0, pcie_raddr}, 64'd0);
      chk("rw_err_count", {48'b0, err_count}, 64'd0);
      chk("rw_outputs", {resp_valid, resp_error, pcie_write, pcie_read, resp_rdata}, 64'd0);
      early = 0;
      for (int c = 0; c < 2; c++) begin
         tick;
         clear_done;
         if (resp_valid != 2'b00) early++;
         drive_done(1'b0, 1'b0, 32'h5555_0000);
      end
      tick;
      clear_done;
      if (resp_valid != 2'b00) early++;
      chk("rw_no_resp", early, 0);
      axi_aresetn = 1'b1;
      req_valid = 2'b11;
      req_write = 2'b00;
      req_addr  = {32'h0000_6004, 32'h0000_6000};
      #1;
      chk("rw_first_grant", {62'b0, req_ready}, 64'd1);
      serve(0, 1'b0, 32'h0000_6000, 32'h0, 2, 1'b0, 32'h600D_0000, 0, 32'h600D_0000, 1'b0, 16'd0, 1'b1);
      req_valid = 2'b00;
      tick;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
